// File: rtl/booth_pkg.sv
// ============================================================================
// booth_pkg : shared states and Booth-pair encodings for booth_sequencer
// Revision  : 1.0
// ============================================================================
`default_nettype none

package booth_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    CHECK = 3'd2,
    SHIFT = 3'd3,
    DONE  = 3'd4
  } booth_state_t;

  localparam logic [1:0] BOOTH_NOP0 = 2'b00;
  localparam logic [1:0] BOOTH_ADD  = 2'b01;
  localparam logic [1:0] BOOTH_SUB  = 2'b10;
  localparam logic [1:0] BOOTH_NOP1 = 2'b11;

  localparam logic ADD_OP = 1'b0;
  localparam logic SUB_OP = 1'b1;

endpackage

`default_nettype wire

// File: rtl/booth_iter_counter.sv
// ============================================================================
// booth_iter_counter : Booth iteration down-counter, flags the final iteration
// Revision           : 1.0
// ============================================================================
`default_nettype none

module booth_iter_counter #(
  parameter int N  = 8,
  parameter int CW = $clog2(N+1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic          dec,
  input  logic          clear,
  output logic [CW-1:0] count,
  output logic          last
);

  logic [CW-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (load) begin
      count_d = CW'(N);
    end else if (dec && (count_q != '0)) begin
      count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;
  assign last  = (count_q == CW'(1));

endmodule

`default_nettype wire

// File: rtl/booth_sequencer.sv
// ============================================================================
// booth_sequencer : control FSM for the radix-2 Booth multiplier datapath
// Revision        : 1.0
// ============================================================================
`default_nettype none

module booth_sequencer
  import booth_pkg::*;
#(
  parameter int N  = 8,
  parameter int CW = $clog2(N+1)
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       clear,
  input  logic [1:0] Q_LSB,
  output logic       load_A,
  output logic       load_B,
  output logic       load_add,
  output logic       add_sub,
  output logic       shift_HQ_LQ_Q_1,
  output logic       busy,
  output logic       done,
  output logic       ready
);

  booth_state_t  state_q, state_d;
  logic          ready_q, ready_d;
  logic          cnt_load, cnt_dec, cnt_last;
  logic [CW-1:0] cnt;

  booth_iter_counter #(
    .N  (N),
    .CW (CW)
  ) u_iter_counter (
    .clk   (clk),
    .rst   (rst),
    .load  (cnt_load),
    .dec   (cnt_dec),
    .clear (clear),
    .count (cnt),
    .last  (cnt_last)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ready_q <= ready_d;
    end
  end

  // busy is decoded from the state register alone so Q_LSB cannot glitch it
  assign busy  = (state_q == LOAD) || (state_q == CHECK) || (state_q == SHIFT);
  assign ready = ready_q;

  always_comb begin
    state_d         = state_q;
    ready_d         = ready_q;
    load_A          = 1'b0;
    load_B          = 1'b0;
    load_add        = 1'b0;
    add_sub         = ADD_OP;
    shift_HQ_LQ_Q_1 = 1'b0;
    done            = 1'b0;
    cnt_load        = 1'b0;
    cnt_dec         = 1'b0;

    if (clear) begin
      state_d = IDLE;
      ready_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            state_d = LOAD;
            ready_d = 1'b0;
          end
        end
        LOAD: begin
          load_A   = 1'b1;
          load_B   = 1'b1;
          cnt_load = 1'b1;
          state_d  = CHECK;
        end
        CHECK: begin
          case (Q_LSB)
            BOOTH_ADD: begin
              load_add = 1'b1;
              add_sub  = ADD_OP;
            end
            BOOTH_SUB: begin
              load_add = 1'b1;
              add_sub  = SUB_OP;
            end
            default: ;
          endcase
          state_d = SHIFT;
        end
        SHIFT: begin
          shift_HQ_LQ_Q_1 = 1'b1;
          cnt_dec         = (cnt != '0);
          if (cnt_last) begin
            state_d = DONE;
            ready_d = 1'b1;
          end else begin
            state_d = CHECK;
          end
        end
        DONE: begin
          done    = 1'b1;
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_booth_sequencer.sv
// ============================================================================
// tb_booth_sequencer : booth_sequencer driving a behavioural Booth datapath
// Revision           : 1.0
// ============================================================================
`default_nettype none

module tb_booth_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic       clear = 1'b0;
  logic [1:0] Q_LSB;
  logic       load_A, load_B, load_add, add_sub, shift_HQ_LQ_Q_1;
  logic       busy, done, ready;

  logic [7:0]  A = 8'h00;
  logic [7:0]  B = 8'h00;
  logic [8:0]  M  = '0;
  logic [8:0]  HQ = '0;
  logic [7:0]  Q  = '0;
  logic        Q1 = 1'b0;
  logic [15:0] Y;

  int tests = 0;
  int fails = 0;
  logic [15:0] sb[$];

  always #5 clk = ~clk;

  booth_sequencer #(.N(8)) dut (
    .clk             (clk),
    .rst             (rst),
    .start           (start),
    .clear           (clear),
    .Q_LSB           (Q_LSB),
    .load_A          (load_A),
    .load_B          (load_B),
    .load_add        (load_add),
    .add_sub         (add_sub),
    .shift_HQ_LQ_Q_1 (shift_HQ_LQ_Q_1),
    .busy            (busy),
    .done            (done),
    .ready           (ready)
  );

  // Datapath with a guard bit on HQ/M so -128 * -128 does not overflow
  always @(posedge clk) begin
    if (load_A) M <= {A[7], A};
    if (load_B) begin
      Q  <= B;
      HQ <= '0;
      Q1 <= 1'b0;
    end
    if (load_add) HQ <= add_sub ? (HQ - M) : (HQ + M);
    if (shift_HQ_LQ_Q_1) {HQ, Q, Q1} <= {HQ[8], HQ, Q};
  end

  assign Q_LSB = {Q[0], Q1};
  assign Y     = {HQ[7:0], Q};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // mode 0: normal, 1: stray start in SHIFT of iter 3, 2: clear in CHECK of iter 5, 3: reset at cycle 7
  task automatic run(input logic [7:0] a, input logic [7:0] b, input int mode);
    int          dones    = 0;
    int          done_cyc = -1;
    int          iter     = 0;
    logic        viol     = 1'b0;
    logic        busy_ok  = 1'b1;
    logic [15:0] ops_v    = '0;
    logic [15:0] exp_v    = '0;
    logic [15:0] got_y    = '0;
    logic        got_rdy  = 1'b0;
    logic [1:0]  pair;
    A = a;
    B = b;
    for (int i = 0; i < 8; i++) begin
      pair = {b[i], (i == 0) ? 1'b0 : b[i-1]};
      exp_v[2*i +: 2] = (pair == 2'b01) ? 2'd1 : (pair == 2'b10) ? 2'd2 : 2'd0;
    end
    if (mode < 2) sb.push_back(16'($signed(a) * $signed(b)));
    start = 1'b1;
    for (int c = 1; c <= 24; c++) begin
      @(negedge clk);
      if (c == 1) begin
        start = 1'b0;
        chk("load_cycle", {29'd0, load_A, load_B, busy}, 32'h7);
      end
      if (int'(load_A) + int'(load_add) + int'(shift_HQ_LQ_Q_1) > 1) viol = 1'b1;
      if (load_A !== load_B) viol = 1'b1;
      if (add_sub && !load_add) viol = 1'b1;
      if (load_add && iter < 8) ops_v[2*iter +: 2] = add_sub ? 2'd2 : 2'd1;
      if (shift_HQ_LQ_Q_1) iter++;
      if (mode < 2 && c <= 17 && busy !== 1'b1) busy_ok = 1'b0;
      if (done) begin
        dones++;
        done_cyc = c;
        got_y    = Y;
        got_rdy  = ready;
      end
      if (mode == 1 && c == 7) start = 1'b1;
      if (mode == 1 && c == 8) start = 1'b0;
      if (mode == 2 && c == 10) clear = 1'b1;
      if (mode == 2 && c == 11) begin
        chk("clear_idle", {30'd0, busy, ready}, 32'h0);
        clear = 1'b0;
      end
      if (mode == 3 && c == 7) begin
        rst = 1'b0;
        #1;
        chk("rst_midrun", {24'd0, load_A, load_B, load_add, add_sub, shift_HQ_LQ_Q_1,
                           busy, done, ready}, 32'h0);
      end
      if (mode == 3 && c == 8) rst = 1'b1;
    end
    chk("strobe_excl", {31'd0, viol}, 32'h0);
    if (mode < 2) begin
      chk("done_count", dones, 1);
      chk("done_cycle", done_cyc, 18);
      chk("busy_window", {31'd0, busy_ok}, 32'h1);
      chk("ready_at_done", {31'd0, got_rdy}, 32'h1);
      chk("booth_ops", {16'd0, ops_v}, {16'd0, exp_v});
      if (sb.size() == 0) begin
        chk("sb_empty", 32'd1, 32'd0);
      end else begin
        chk("result_Y", {16'd0, got_y}, {16'd0, sb.pop_front()});
      end
      chk("ready_held", {30'd0, ready, busy}, 32'h2);
    end else begin
      chk("abort_no_done", dones, 0);
      chk("abort_idle", {30'd0, busy, ready}, 32'h0);
    end
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("reset_outputs", {24'd0, load_A, load_B, load_add, add_sub, shift_HQ_LQ_Q_1,
                          busy, done, ready}, 32'h0);
    rst = 1'b1;
    @(negedge clk);

    run(8'd5, 8'd7, 3);
    run(8'd5, 8'd3, 0);
    run(8'hFD, 8'h07, 0);
    run(8'h80, 8'h80, 0);
    run(8'd9, 8'd11, 1);
    run(8'h7F, 8'h81, 2);
    @(negedge clk);
    @(negedge clk);
    run(8'h7F, 8'h81, 0);

    start = 1'b1;
    clear = 1'b1;
    @(negedge clk);
    start = 1'b0;
    clear = 1'b0;
    chk("clear_beats_start", {31'd0, busy}, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
